// File: rtl/flash_pkg.sv
// Shared constants, state encoding and byte-packing helper for the SPI flash boot loader.
package flash_pkg;

  localparam logic [7:0] FlashReadCommand     = 8'h03;
  localparam int         FlashAddressBitWidth = 24;
  localparam int         FlashWordBitWidth    = 32;
  localparam int         BitIndexBitWidth     = $clog2(FlashWordBitWidth);

  // Each SPI bit spends the first half of this many clk cycles low, the second half high.
  localparam int SpiClkPerBit     = 2;
  localparam int SpiPhaseBitWidth = (SpiClkPerBit > 1) ? $clog2(SpiClkPerBit) : 1;

  typedef enum logic [2:0] {
    Idle,
    SendCommand,
    SendAddress,
    ReceiveData,
    WaitWrite,
    Finish
  } loader_state_e;

  // Bytes arrive first-byte-in-MSBs; the RAM wants the first byte in [7:0].
  function automatic logic [FlashWordBitWidth-1:0] pack_le(
    input logic [FlashWordBitWidth-1:0] msb_first
  );
    return {msb_first[7:0], msb_first[15:8], msb_first[23:16], msb_first[31:24]};
  endfunction

endpackage

// File: rtl/flash_loader_spi_bit_engine.sv
// SPI mode-0 style bit engine: phase toggle, shared in/out shift register and bit counter.
module spi_bit_engine
  import flash_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [FlashWordBitWidth-1:0]  load_data,
  input  logic                          run,
  input  logic                          hold,
  input  logic                          shift_out,
  input  logic                          miso,
  output logic                          sclk,
  output logic                          mosi,
  output logic                          bit_done,
  output logic [BitIndexBitWidth-1:0]   bit_index,
  output logic [FlashWordBitWidth-1:0]  rx_word
);

  logic [SpiPhaseBitWidth-1:0]    phase;
  logic [FlashWordBitWidth-2:0]   shift_q;
  logic                           last_phase;
  logic                           last_bit;

  assign last_phase = (int'(phase) == SpiClkPerBit - 1);
  assign last_bit   = (bit_index == BitIndexBitWidth'(FlashWordBitWidth - 1));
  assign bit_done   = run && !hold && last_phase;
  assign rx_word    = {shift_q, miso};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= '0;
      bit_index <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
    end else if (load) begin
      // The MSB goes straight to the pin so it is valid for the very first low phase.
      phase     <= '0;
      bit_index <= '0;
      sclk      <= 1'b0;
      mosi      <= shift_out & load_data[FlashWordBitWidth-1];
    end else if (!run || hold) begin
      phase <= '0;
      sclk  <= 1'b0;
      mosi  <= 1'b0;
    end else if (bit_done) begin
      phase     <= '0;
      sclk      <= 1'b0;
      bit_index <= bit_index + 1'b1;
      mosi      <= shift_out && !last_bit && shift_q[FlashWordBitWidth-2];
    end else begin
      phase <= phase + 1'b1;
      sclk  <= (int'(phase) + 1 >= SpiClkPerBit / 2);
    end
  end

  // Outgoing bits leave from the top while sampled miso bits enter at the bottom.
  always_ff @(posedge clk) begin
    if (load) begin
      shift_q <= load_data[FlashWordBitWidth-2:0];
    end else if (bit_done) begin
      shift_q <= {shift_q[FlashWordBitWidth-3:0], miso};
    end
  end

endmodule

// File: rtl/flash_loader.sv
// Boot loader: streams a block of SPI flash into word-addressed RAM over a valid/ready port.
module flash_loader
  import flash_pkg::*;
#(
  parameter int         CountBitWidth = 16,
  parameter logic [7:0] ReadCommand   = FlashReadCommand
) (
  input  logic                             rst_n,
  input  logic                             clk,
  input  logic                             start,
  input  logic [FlashAddressBitWidth-1:0]  flash_address,
  input  logic [CountBitWidth-1:0]         word_count,
  output logic                             busy,
  output logic                             done,
  output logic                             flash_clk,
  output logic                             flash_cs,
  output logic                             flash_mosi,
  input  logic                             flash_miso,
  output logic                             wr_valid,
  input  logic                             wr_ready,
  output logic [FlashWordBitWidth-1:0]     wr_data,
  output logic [CountBitWidth-1:0]         wr_index
);

  localparam logic [BitIndexBitWidth-1:0] CommandLastBit = BitIndexBitWidth'(7);
  localparam logic [BitIndexBitWidth-1:0] WordLastBit    = BitIndexBitWidth'(FlashWordBitWidth - 1);

  loader_state_e                  state;
  logic [CountBitWidth-1:0]       count_q;
  logic                           start_accept;
  logic                           eng_run;
  logic                           eng_hold;
  logic                           eng_shift_out;
  logic                           bit_done;
  logic [BitIndexBitWidth-1:0]    bit_index;
  logic [FlashWordBitWidth-1:0]   rx_word;

  assign start_accept  = (state == Idle) && start && (word_count != '0);
  assign eng_run       = state inside {SendCommand, SendAddress, ReceiveData, WaitWrite};
  assign eng_hold      = (state == WaitWrite);
  assign eng_shift_out = state inside {Idle, SendCommand, SendAddress};

  spi_bit_engine u_spi_bit_engine (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (start_accept),
    .load_data ({ReadCommand, flash_address}),
    .run       (eng_run),
    .hold      (eng_hold),
    .shift_out (eng_shift_out),
    .miso      (flash_miso),
    .sclk      (flash_clk),
    .mosi      (flash_mosi),
    .bit_done  (bit_done),
    .bit_index (bit_index),
    .rx_word   (rx_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= Idle;
      busy     <= 1'b0;
      done     <= 1'b0;
      flash_cs <= 1'b1;
      wr_valid <= 1'b0;
      wr_data  <= '0;
      wr_index <= '0;
      count_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        Idle: begin
          if (start) begin
            if (word_count != '0) begin
              count_q  <= word_count;
              wr_index <= '0;
              busy     <= 1'b1;
              flash_cs <= 1'b0;
              state    <= SendCommand;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SendCommand: begin
          if (bit_done && bit_index == CommandLastBit) begin
            state <= SendAddress;
          end
        end
        SendAddress: begin
          // The bit counter keeps running across command and address: 32 bits in total.
          if (bit_done && bit_index == WordLastBit) begin
            state <= ReceiveData;
          end
        end
        ReceiveData: begin
          if (bit_done && bit_index == WordLastBit) begin
            wr_valid <= 1'b1;
            wr_data  <= pack_le(rx_word);
            state    <= WaitWrite;
          end
        end
        WaitWrite: begin
          // flash_clk is parked low here, so the flash keeps the next bit on miso.
          if (wr_ready) begin
            wr_valid <= 1'b0;
            if (wr_index == count_q - CountBitWidth'(1)) begin
              flash_cs <= 1'b1;
              state    <= Finish;
            end else begin
              wr_index <= wr_index + CountBitWidth'(1);
              state    <= ReceiveData;
            end
          end
        end
        Finish: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= Idle;
        end
        default: begin
          flash_cs <= 1'b1;
          busy     <= 1'b0;
          wr_valid <= 1'b0;
          state    <= Idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_loader.sv
// Bench for flash_loader: pin-level flash emulator plus a byte-array model of the expected words.
module tb_flash_loader;
  import flash_pkg::*;

  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [23:0]    flash_address;
  logic [CW-1:0]  word_count;
  logic           busy;
  logic           done;
  logic           flash_clk;
  logic           flash_cs;
  logic           flash_mosi;
  logic           flash_miso = 1'b0;
  logic           wr_valid;
  logic           wr_ready;
  logic [31:0]    wr_data;
  logic [CW-1:0]  wr_index;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] mem [256];

  int          emu_rise = 0;
  int          emu_bit  = 0;
  int          emu_b    = 0;
  logic [7:0]  emu_a    = 8'h00;
  logic [31:0] emu_hdr  = 32'h0;

  flash_loader #(
    .CountBitWidth (CW),
    .ReadCommand   (8'h03)
  ) dut (
    .rst_n         (rst_n),
    .clk           (clk),
    .start         (start),
    .flash_address (flash_address),
    .word_count    (word_count),
    .busy          (busy),
    .done          (done),
    .flash_clk     (flash_clk),
    .flash_cs      (flash_cs),
    .flash_mosi    (flash_mosi),
    .flash_miso    (flash_miso),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .wr_index      (wr_index)
  );

  always #5 clk = ~clk;

  // Flash device: 32 header bits on rising flash_clk, data bits shifted out on falling flash_clk.
  always @(posedge flash_clk or negedge flash_clk or posedge flash_cs) begin
    if (flash_cs) begin
      emu_rise = 0;
      emu_bit  = 0;
    end else if (flash_clk) begin
      if (emu_rise < 32) emu_hdr = {emu_hdr[30:0], flash_mosi};
      emu_rise++;
    end else if (emu_rise >= 32) begin
      emu_a      = emu_hdr[7:0] + 8'(emu_bit / 8);
      emu_b      = 7 - (emu_bit % 8);
      flash_miso = mem[emu_a][emu_b];
      emu_bit++;
    end
  end

  function automatic logic [31:0] exp_word(input logic [23:0] a, input int k);
    logic [31:0] w;
    logic [7:0]  idx;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      idx = a[7:0] + 8'(4 * k + b);
      w[8*b +: 8] = mem[idx];
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_transfer(input string name, input logic [23:0] addr, input int cnt,
                              input int ready_pct, input int stall_word, input int stall_len,
                              input int poke_at, input int abort_at);
    int          cyc, done_cyc, k, waits, cs_low, bits, valid_cycles, stalled, limit;
    logic [31:0] hdr, hold_data;
    logic [CW-1:0] hold_idx;
    logic        quiet;
    cyc = 0; done_cyc = -1; k = 0; waits = 0; cs_low = 0; bits = 0;
    valid_cycles = 0; stalled = 0; hdr = '0; hold_data = '0; hold_idx = '0;
    limit = 200 + 66 + 65 * cnt + stall_len + 40 * cnt;
    flash_address = addr;
    word_count    = CW'(cnt);
    start         = 1'b1;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == poke_at) begin
        start         = 1'b1;
        flash_address = 24'($urandom);
        word_count    = CW'($urandom_range(1, 5));
      end
      if (cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        check({name, "_rst_cs"}, 64'(flash_cs), 64'(1));
        check({name, "_rst_busy"}, 64'(busy), 64'(0));
        check({name, "_rst_valid"}, 64'(wr_valid), 64'(0));
        check({name, "_rst_sclk"}, 64'(flash_clk), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (8) begin
          @(negedge clk);
          if (done || !flash_cs) quiet = 1'b0;
        end
        check({name, "_quiet_after_rst"}, 64'(quiet), 64'(1));
        return;
      end
      if (!flash_cs) cs_low++;
      if (flash_clk) begin
        if (bits < 32) hdr = {hdr[30:0], flash_mosi};
        bits++;
      end
      if (cyc == 1) check({name, "_busy_c1"}, 64'(busy), 64'(cnt != 0));
      if (done) begin
        done_cyc = cyc;
        check({name, "_busy_at_done"}, 64'(busy), 64'(0));
        @(negedge clk);
        check({name, "_done_pulse"}, 64'(done), 64'(0));
        check({name, "_cs_after_done"}, 64'(flash_cs), 64'(1));
        break;
      end
      if (wr_valid) begin
        valid_cycles++;
        if (stall_word == int'(wr_index) && stalled < stall_len) begin
          if (stalled == 0) begin
            hold_data = wr_data;
            hold_idx  = wr_index;
          end else begin
            check({name, "_stall_sclk"}, 64'(flash_clk), 64'(0));
            check({name, "_stall_data"}, 64'(wr_data), 64'(hold_data));
            check({name, "_stall_idx"}, 64'(wr_index), 64'(hold_idx));
          end
          wr_ready = 1'b0;
          stalled++;
        end else begin
          wr_ready = ($urandom_range(99) < ready_pct);
        end
        if (wr_ready) begin
          check({name, "_index"}, 64'(wr_index), 64'(k));
          check({name, "_data"}, 64'(wr_data), 64'(exp_word(addr, k)));
          k++;
        end else begin
          waits++;
        end
      end else begin
        wr_ready = 1'($urandom_range(1));
      end
    end
    check({name, "_words"}, 64'(k), 64'(cnt));
    check({name, "_done_cycle"}, 64'(done_cyc), 64'((cnt == 0) ? 1 : 66 + 65 * cnt + waits));
    check({name, "_cs_low"}, 64'(cs_low), 64'((cnt == 0) ? 0 : 64 + 65 * cnt + waits));
    check({name, "_sclk_bits"}, 64'(bits), 64'((cnt == 0) ? 0 : 32 + 32 * cnt));
    check({name, "_valid_cycles"}, 64'(valid_cycles), 64'(cnt + waits));
    if (cnt > 0) check({name, "_mosi_hdr"}, 64'(hdr), 64'({8'h03, addr}));
  endtask

  initial begin
    logic [23:0] addr;
    int          cnt;
    rst_n         = 1'b0;
    start         = 1'b0;
    flash_address = '0;
    word_count    = '0;
    wr_ready      = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clk);

    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_sclk", 64'(flash_clk), 64'(0));
    check("reset_cs", 64'(flash_cs), 64'(1));
    check("reset_mosi", 64'(flash_mosi), 64'(0));
    check("reset_valid", 64'(wr_valid), 64'(0));
    check("reset_data", 64'(wr_data), 64'(0));
    check("reset_index", 64'(wr_index), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_transfer("basic", 24'h000000, 2, 100, -1, 0, -1, -1);
    run_transfer("backpressure", 24'h000000, 2, 100, 0, 20, -1, -1);
    run_transfer("zero_count", 24'h000010, 0, 100, -1, 0, -1, -1);
    run_transfer("abort", 24'h000000, 2, 100, -1, 0, -1, 80);
    run_transfer("after_reset", 24'h000004, 1, 100, -1, 0, -1, -1);
    run_transfer("start_while_busy", 24'h000020, 2, 100, -1, 0, 100, -1);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      addr = (t == 0) ? 24'hFFFFFA : 24'($urandom);
      cnt  = $urandom_range(1, 4);
      run_transfer("random", addr, cnt, 60, -1, 0, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
